// File: rtl/spi_slave_byte_engine_pkg.sv
// Shared constants and encodings for the SPI slave byte engine and the data transfer controller.
package spi_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;

    // Controller state encoding lives here so both sides agree on it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIZE = 2'd1,
        DATA = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/spi_slave_byte_engine_if.sv
// SPI pins plus the byte-level handshake towards the data transfer controller.
interface spi_slave_byte_engine_if;
    import spi_pkg::*;

    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [SPI_BYTE_W-1:0] spi_byte_out;
    logic [SPI_BYTE_W-1:0] spi_byte_in;
    logic                  spi_cycle_done;
    logic                  spi_active;
    logic                  frame_error;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, spi_byte_out,
        output spi_miso, spi_miso_oe, spi_byte_in, spi_cycle_done, spi_active, frame_error
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, spi_byte_out,
        input  spi_miso, spi_miso_oe, spi_byte_in, spi_cycle_done, spi_active, frame_error
    );

endinterface

// File: rtl/spi_slave_byte_engine_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin, with one extra delay flop for edge detection.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= {SYNC_STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], din};
            level_q <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/spi_slave_byte_engine.sv
// Oversampled mode-0 SPI slave: deserialises MOSI into bytes and serialises the controller's byte onto MISO.
module spi_slave_byte_engine
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DONE_HOLD   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_slave_byte_engine_if.slave  bus
);

    localparam int DW = $clog2(DONE_HOLD + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic selected;

    logic [SPI_BIT_CNT_W-1:0] bit_cnt;
    logic [SPI_BYTE_W-1:0]    rx_shift;
    logic [SPI_BYTE_W-1:0]    rx_next;
    logic [SPI_BYTE_W-1:0]    tx_shift;
    logic [SPI_BYTE_W-1:0]    byte_in_q;
    logic                     frame_error_q;

    logic          done_start;
    logic          done_retrig;
    logic          retrig_next;
    logic [DW-1:0] done_cnt;
    logic [DW-1:0] done_next;
    logic          cycle_done_q;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(bus.spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_N_IDLE)) u_cs_sync (
        .clk(clk), .rst(rst), .din(bus.spi_cs_n),
        .level(cs_n_s), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(bus.spi_mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign selected = ~cs_n_s;
    assign rx_next  = {rx_shift[SPI_BYTE_W-2:0], mosi_s};

    // cs_n edges take priority over sclk; clearing tx_shift on deselect keeps MISO low while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            byte_in_q     <= '0;
            frame_error_q <= 1'b0;
            done_start    <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            done_start    <= 1'b0;
            if (cs_rise) begin
                frame_error_q <= (bit_cnt != '0);
                bit_cnt       <= '0;
                tx_shift      <= '0;
            end else if (cs_fall) begin
                bit_cnt  <= '0;
                tx_shift <= bus.spi_byte_out;
            end else if (selected) begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + SPI_BIT_CNT_W'(1);
                    if (bit_cnt == {SPI_BIT_CNT_W{1'b1}}) begin
                        byte_in_q  <= rx_next;
                        done_start <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (bit_cnt != '0) begin
                        tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                    end else begin
                        tx_shift <= bus.spi_byte_out;
                    end
                end
            end
        end
    end

    // A byte finishing while the strobe is still high forces one low clk so the controller sees a fresh edge.
    always_comb begin
        done_next   = (done_cnt != '0) ? done_cnt - DW'(1) : '0;
        retrig_next = 1'b0;
        if (done_retrig) begin
            done_next = DW'(DONE_HOLD);
        end else if (done_start) begin
            if (done_cnt != '0) begin
                done_next   = '0;
                retrig_next = 1'b1;
            end else begin
                done_next = DW'(DONE_HOLD);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_cnt     <= '0;
            done_retrig  <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            done_cnt     <= done_next;
            done_retrig  <= retrig_next;
            cycle_done_q <= (done_next != '0);
        end
    end

    assign bus.spi_miso       = tx_shift[SPI_BYTE_W-1];
    assign bus.spi_miso_oe    = selected;
    assign bus.spi_active     = selected;
    assign bus.spi_byte_in    = byte_in_q;
    assign bus.spi_cycle_done = cycle_done_q;
    assign bus.frame_error    = frame_error_q;

endmodule

// File: tb/tb_spi_slave_byte_engine.sv
// Directed and randomized bench for spi_slave_byte_engine, acting as SPI master and loopback controller.
module tb_spi_slave_byte_engine;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_slave_byte_engine_if bus();

    spi_slave_byte_engine #(.SYNC_STAGES(2), .DONE_HOLD(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int         done_rises    = 0;
    int         done_len      = 0;
    int         last_done_len = 0;
    int         lead_errs     = 0;
    int         fe_rises      = 0;
    int         fe_cycles     = 0;
    int         oe_errs       = 0;
    logic       done_d        = 1'b0;
    logic       fe_d          = 1'b0;
    logic [7:0] byte_in_d     = 8'h00;
    logic [7:0] rx_q[$];
    bit         loopback      = 1'b0;

    // Passive observer plus a loopback controller that returns each received byte as the next one to send.
    always @(negedge clk) begin
        if (bus.spi_cycle_done) begin
            done_len++;
            if (!done_d) begin
                done_rises++;
                rx_q.push_back(bus.spi_byte_in);
                if (byte_in_d !== bus.spi_byte_in) lead_errs++;
                if (loopback) bus.spi_byte_out = bus.spi_byte_in;
            end
        end else if (done_d) begin
            last_done_len = done_len;
            done_len      = 0;
        end
        if (bus.frame_error) begin
            fe_cycles++;
            if (!fe_d) fe_rises++;
        end
        done_d    = bus.spi_cycle_done;
        fe_d      = bus.frame_error;
        byte_in_d = bus.spi_byte_in;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        done_rises = 0;
        fe_rises   = 0;
        fe_cycles  = 0;
        lead_errs  = 0;
        oe_errs    = 0;
    endtask

    task automatic select_slave();
        bus.spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic deselect_slave();
        repeat (4) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode 0 master at sclk = clk/8: MOSI set while sclk is low, MISO sampled just before the rising edge.
    task automatic apply_stimulus(input logic [7:0] data, input int nbits, output logic [7:0] miso_byte);
        miso_byte = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = data[7-i];
            repeat (4) @(negedge clk);
            miso_byte[7-i] = bus.spi_miso;
            if (bus.spi_miso_oe !== 1'b1) oe_errs++;
            bus.spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " byte_in"},     32'(bus.spi_byte_in),    32'h0);
        check_output({tag, " cycle_done"},  32'(bus.spi_cycle_done), 32'h0);
        check_output({tag, " miso"},        32'(bus.spi_miso),       32'h0);
        check_output({tag, " miso_oe"},     32'(bus.spi_miso_oe),    32'h0);
        check_output({tag, " active"},      32'(bus.spi_active),     32'h0);
        check_output({tag, " frame_error"}, 32'(bus.frame_error),    32'h0);
    endtask

    logic [7:0] miso_byte;
    logic [7:0] data;
    logic [7:0] first_out;
    logic [7:0] sent[256];
    logic [7:0] echoed[256];
    logic [7:0] got;
    logic [7:0] exp_echo;

    initial begin
        bus.spi_sclk     = SCLK_IDLE;
        bus.spi_cs_n     = CS_N_IDLE;
        bus.spi_mosi     = 1'b0;
        bus.spi_byte_out = 8'h00;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte 0x01: value, strobe width, strobe count, setup lead.
        clear_counters();
        select_slave();
        check_output("active while selected", 32'(bus.spi_active), 32'h1);
        apply_stimulus(8'h01, 8, miso_byte);
        repeat (8) @(negedge clk);
        check_output("byte 0x01 received", 32'(bus.spi_byte_in), 32'h01);
        check_output("byte 0x01 done count", 32'(done_rises), 32'd1);
        check_output("done high width", 32'(last_done_len), 32'd2);
        check_output("byte_in leads done", 32'(lead_errs), 32'd0);
        check_output("no frame error on full byte", 32'(fe_rises), 32'd0);
        deselect_slave();
        check_output("inactive after deselect", 32'(bus.spi_active), 32'h0);

        // Four-byte frame with the transmit byte held constant.
        clear_counters();
        bus.spi_byte_out = 8'hC3;
        select_slave();
        for (int b = 0; b < 4; b++) begin
            data = 8'($urandom);
            apply_stimulus(data, 8, miso_byte);
            check_output($sformatf("held miso byte %0d", b), 32'(miso_byte), 32'hC3);
            check_output($sformatf("held rx byte %0d", b), 32'(bus.spi_byte_in), 32'(data));
        end
        deselect_slave();
        check_output("miso_oe during frame", 32'(oe_errs), 32'd0);
        check_output("four byte done count", 32'(done_rises), 32'd4);
        got = bus.spi_byte_in;

        // Deselect after five bits: one-clk frame error, no strobe, byte_in untouched.
        clear_counters();
        select_slave();
        apply_stimulus(8'hFF, 5, miso_byte);
        deselect_slave();
        check_output("partial frame error count", 32'(fe_rises), 32'd1);
        check_output("partial frame error width", 32'(fe_cycles), 32'd1);
        check_output("partial no done", 32'(done_rises), 32'd0);
        check_output("partial byte_in kept", 32'(bus.spi_byte_in), 32'(got));
        select_slave();
        apply_stimulus(8'h7E, 8, miso_byte);
        deselect_slave();
        check_output("byte 0x7E after error", 32'(bus.spi_byte_in), 32'h7E);
        check_output("byte 0x7E done count", 32'(done_rises), 32'd1);

        // Seven bits, then cs_n and sclk rise together: the deselect wins and the eighth edge is lost.
        clear_counters();
        select_slave();
        apply_stimulus(8'h5A, 7, miso_byte);
        bus.spi_mosi = 1'b1;
        repeat (4) @(negedge clk);
        bus.spi_sclk = 1'b1;
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        bus.spi_sclk = 1'b0;
        repeat (8) @(negedge clk);
        check_output("simultaneous rise frame error", 32'(fe_rises), 32'd1);
        check_output("simultaneous rise no done", 32'(done_rises), 32'd0);
        check_output("simultaneous rise byte_in kept", 32'(bus.spi_byte_in), 32'h7E);

        // Asynchronous reset mid-byte, then a fresh frame.
        select_slave();
        apply_stimulus(8'hA5, 4, miso_byte);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid-byte reset");
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        clear_counters();
        repeat (4) @(negedge clk);
        select_slave();
        apply_stimulus(8'h81, 8, miso_byte);
        deselect_slave();
        check_output("byte 0x81 after reset", 32'(bus.spi_byte_in), 32'h81);
        check_output("one done since reset", 32'(done_rises), 32'd1);

        // 256 random bytes back-to-back through the loopback controller.
        clear_counters();
        rx_q.delete();
        first_out        = 8'($urandom);
        bus.spi_byte_out = first_out;
        loopback         = 1'b1;
        select_slave();
        for (int k = 0; k < 256; k++) begin
            sent[k] = 8'($urandom);
            apply_stimulus(sent[k], 8, echoed[k]);
        end
        deselect_slave();
        loopback = 1'b0;
        check_output("random done count", 32'(done_rises), 32'd256);
        check_output("random received count", 32'(rx_q.size()), 32'd256);
        check_output("random miso_oe", 32'(oe_errs), 32'd0);
        check_output("random byte_in leads done", 32'(lead_errs), 32'd0);
        for (int k = 0; k < 256; k++) begin
            got      = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            exp_echo = (k == 0) ? first_out : sent[k-1];
            check_output($sformatf("random rx byte %0d", k), 32'(got), 32'(sent[k]));
            check_output($sformatf("random miso echo %0d", k), 32'(echoed[k]), 32'(exp_echo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
